// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD score converter:
// FSM state encoding, digit adjust constants and the saturation limit helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_bcd_value(input int digits);
    logic [63:0] pow_s;
    pow_s = 64'd1;
    for (int i = 0; i < digits; i++) begin
      pow_s = pow_s * 64'd10;
    end
    return pow_s - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               unused_tie,
  output logic [DIGIT_W-1:0] digit_out
);

  logic unused_s;
  assign unused_s = unused_tie;

  // Shift-add-3 correction.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADJ_THRESH) begin
      digit_out = digit_in + ADJ_ADD;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bcd_score_converter.sv
// Sequential double-dabble converter: one bit per clock, start/done handshake, saturating.
// Optional macro LEADING_ZERO_BLANK_EN enables per-digit leading-zero blank flags.
module bcd_score_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 24,
  parameter int DIGITS = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_value,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    overflow,
  output logic [DIGITS-1:0]       blank
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0]      MAX_VAL  = max_bcd_value(DIGITS);
  localparam logic [BIN_W-1:0] SAT_VAL  = MAX_VAL[BIN_W-1:0];
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [SCR_W-1:0]  scratch_r, scratch_s;
  logic              ovf_pending_r, ovf_pending_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [BCD_W-1:0]  bcd_r, bcd_s;
  logic              overflow_r, overflow_s;

  logic [63:0]       bin_ext_s;
  logic [BCD_W-1:0]  adj_bcd_s;
  logic [SCR_W-1:0]  shifted_s;
  logic [BCD_W-1:0]  final_bcd_s;

  assign bin_ext_s   = 64'(bin_value);
  assign final_bcd_s = scratch_r[SCR_W-1 -: BCD_W];
  assign shifted_s   = {adj_bcd_s[BCD_W-2:0], scratch_r[BIN_W-1:0], 1'b0};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (scratch_r[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .unused_tie(1'b0),
      .digit_out (adj_bcd_s[DIGIT_W*g +: DIGIT_W])
    );
  end

  // State and datapath registers; synchronous active-low reset clears everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      scratch_r     <= {SCR_W{1'b0}};
      ovf_pending_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      bcd_r         <= {BCD_W{1'b0}};
      overflow_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      scratch_r     <= scratch_s;
      ovf_pending_r <= ovf_pending_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      bcd_r         <= bcd_s;
      overflow_r    <= overflow_s;
    end
  end

  // Next-state and next-output logic; busy/done are the registered view of the next state.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    scratch_s     = scratch_r;
    ovf_pending_s = ovf_pending_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    bcd_s         = bcd_r;
    overflow_s    = overflow_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          cnt_s   = {CNT_W{1'b0}};
          busy_s  = 1'b1;
          // Out-of-range inputs convert the saturation value through the same path.
          if (bin_ext_s > MAX_VAL) begin
            scratch_s     = {{BCD_W{1'b0}}, SAT_VAL};
            ovf_pending_s = 1'b1;
          end else begin
            scratch_s     = {{BCD_W{1'b0}}, bin_value};
            ovf_pending_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      SHIFT: begin
        scratch_s = shifted_s;
        busy_s    = 1'b1;
        if (cnt_r == LAST_CNT) begin
          state_s = DONE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = SHIFT;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s    = IDLE;
        busy_s     = 1'b0;
        done_s     = 1'b1;
        bcd_s      = final_bcd_s;
        overflow_s = ovf_pending_r;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign bcd      = bcd_r;
  assign overflow = overflow_r;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_r;
  logic [DIGITS-1:0] blank_calc_s;
  logic              seen_nz_s;

  // Scan from the top digit down; digits above the first nonzero one are blanked.
  always_comb begin
    blank_calc_s = {DIGITS{1'b0}};
    seen_nz_s    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (final_bcd_s[DIGIT_W*i +: DIGIT_W] != 4'd0) begin
        seen_nz_s = 1'b1;
      end else begin
        seen_nz_s = seen_nz_s;
      end
      blank_calc_s[i] = ~seen_nz_s;
    end
  end

  // Blank flags update together with bcd on the completion edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      blank_r <= {DIGITS{1'b0}};
    end else if (state_r == DONE) begin
      blank_r <= blank_calc_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`else
  assign blank = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_bcd_score_converter.sv
// Scoreboard bench for bcd_score_converter: stimulus pushes decimal-model expectations,
// a negedge monitor pops and compares on every done pulse (including latency).
module tb_bcd_score_converter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] bin_value;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        overflow;
  logic [5:0]  blank;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blank;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  bcd_score_converter #(.BIN_W(24), .DIGITS(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_value(bin_value),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .blank    (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Decimal reference: saturate, then peel digits with %10.
  function automatic exp_t model(input longint unsigned v, input int done_cyc);
    exp_t e;
    longint unsigned s;
    int nd;
    e.ovf = (v > 64'd999999);
    s = e.ovf ? 64'd999999 : v;
    e.bcd = 24'h0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      e.bcd[4*i +: 4] = 4'(s % 10);
      if (s != 0) nd = i + 1;
      s = s / 10;
    end
    if (nd == 0) nd = 1;
    e.blank = 6'b0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 6; i++) e.blank[i] = (i >= nd);
`endif
    e.cyc = done_cyc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcd", 64'(bcd), 64'(e.bcd));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("blank", 64'(blank), 64'(e.blank));
        check("busy_at_done", 64'(busy), 64'd0);
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge with the DUT idle; accept happens on the next posedge.
  task automatic issue(input logic [23:0] v);
    start     = 1'b1;
    bin_value = v;
    exp_q.push_back(model(64'(v), cyc + 26));
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    bin_value = 24'($urandom);
  endtask

  task automatic wait_done();
    int got;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (got == 0) check("done_timeout", 64'd0, 64'd1);
    @(negedge clock);
  endtask

  task automatic convert(input logic [23:0] v);
    issue(v);
    wait_done();
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    bin_value = 24'h0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_blank", 64'(blank), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    convert(24'd0);
    convert(24'd123456);
    convert(24'd999999);
    convert(24'd1000000);
    convert(24'hFFFFFF);
    convert(24'd5);
    convert(24'd42);

    // Start pulses during a conversion must be ignored.
    issue(24'd42);
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clock);

    // Start held high: two back-to-back conversions; bin_value change after accept is harmless.
    begin
      logic [23:0] v1, v2;
      v1 = 24'($urandom_range(0, 999999));
      v2 = 24'($urandom_range(0, 999999));
      start     = 1'b1;
      bin_value = v1;
      exp_q.push_back(model(64'(v1), cyc + 26));
      exp_q.push_back(model(64'(v2), cyc + 52));
      @(negedge clock);
      bin_value = v2;
      repeat (27) @(negedge clock);
      start = 1'b0;
      wait_done();
    end

    for (int i = 0; i < 14; i++) begin
      if (i % 3 == 0) convert(24'($urandom));
      else convert(24'($urandom_range(0, 999999)));
    end

    // Reset mid-conversion aborts and clears outputs; no done may follow.
    issue(24'd777777);
    repeat (11) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    void'(exp_q.pop_back());
    repeat (40) @(negedge clock);

    convert(24'd9);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
